wb_byte_master: RTL and testbench

//  Byte-stream-to-Wishbone initiator: parses read/write commands from a byte source
//  (UART RX FIFO side) and issues single 32-bit pipelined Wishbone transactions.

---
 rtl/wb_byte_master_pkg.sv | 22 ++
 rtl/wb_byte_master.sv | 186 ++++++++++++++++++
 tb/tb_wb_byte_master.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_byte_master_pkg.sv
// Shared constants for the byte-stream Wishbone debug initiator.
// Covers command bytes, status bytes and the control FSM state encoding.
// Contains no logic, so it adds no latency and has no backpressure.
package wb_byte_master_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'

    localparam logic [7:0] ST_OK  = 8'h4B;  // 'K' : slave acked
    localparam logic [7:0] ST_ERR = 8'h45;  // 'E' : slave signalled err
    localparam logic [7:0] ST_TMO = 8'h54;  // 'T' : no answer in time

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        REQ  = 3'd3,
        WAIT = 3'd4,
        RESP = 3'd5
    } state_e;

endpackage

// File: rtl/wb_byte_master.sv
// Byte-stream command parser that issues single 32-bit pipelined Wishbone cycles.
// Latency: last frame byte accepted -> cyc/stb next cycle; ack/err -> tx_valid next cycle.
// Backpressure: rx_ready drops while a bus cycle or response is active; tx bytes hold until tx_ready.
module wb_byte_master
    import wb_byte_master_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_stall
);

    // Last count value before the timeout fires; cyc stays up exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;       // byte index shared by ADDR, DATA and RESP
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [7:0]       stat_q, stat_d;
    logic             hdr_q, hdr_d;       // status byte still pending in RESP
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             live_q;             // keeps rx_ready low while and just after reset

    logic             rx_fire;
    logic             tx_fire;
    logic             in_bus;
    logic             tmo;
    logic [7:0]       rbyte;

    assign rx_fire = rx_valid & rx_ready;
    assign tx_fire = tx_valid & tx_ready;
    assign in_bus  = (state_q == REQ) || (state_q == WAIT);
    assign tmo     = (cnt_q == CNT_LAST);

    // Outputs decode straight from registered state so reset clears them asynchronously.
    assign rx_ready = live_q && ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
    assign wb_cyc   = in_bus;
    assign wb_stb   = (state_q == REQ);
    assign wb_we    = in_bus & we_q;
    assign wb_sel   = in_bus ? 4'hF : 4'h0;
    assign wb_adr   = adr_q;
    assign wb_dat_o = dat_q;
    assign tx_valid = (state_q == RESP);

    // Select the outgoing read-data byte, most significant first.
    always_comb begin
        rbyte = rdat_q[31:24];
        case (idx_q)
            2'd0: rbyte = rdat_q[31:24];
            2'd1: rbyte = rdat_q[23:16];
            2'd2: rbyte = rdat_q[15:8];
            2'd3: rbyte = rdat_q[7:0];
            default: rbyte = rdat_q[31:24];
        endcase
    end

    assign tx_data = (state_q != RESP) ? 8'h00 : (hdr_q ? stat_q : rbyte);

    // Frame parsing, bus cycle control, timeout and response sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdat_d  = rdat_q;
        stat_d  = stat_q;
        hdr_d   = hdr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // Anything that is not a command byte is junk and gets dropped here.
                if (rx_fire && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
                    we_d    = (rx_data == CMD_WR);
                    idx_d   = 2'd0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], rx_data};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = we_q ? DATA : REQ;
                    end
                end
            end
            DATA: begin
                if (rx_fire) begin
                    dat_d = {dat_q[23:0], rx_data};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // ack/err only count once the request is accepted (always true in WAIT).
                if ((state_q == WAIT || !wb_stall) && (wb_ack || wb_err)) begin
                    stat_d  = wb_err ? ST_ERR : ST_OK;
                    rdat_d  = wb_dat_i;
                    hdr_d   = 1'b1;
                    idx_d   = 2'd0;
                    state_d = RESP;
                end else if (tmo) begin
                    stat_d  = ST_TMO;
                    hdr_d   = 1'b1;
                    idx_d   = 2'd0;
                    state_d = RESP;
                end else if (state_q == REQ && !wb_stall) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (hdr_q) begin
                        // Only a successful read carries data bytes after the status.
                        if (!we_q && (stat_q == ST_OK)) begin
                            hdr_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
            rdat_q  <= 32'h0;
            stat_q  <= 8'h00;
            hdr_q   <= 1'b0;
            cnt_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdat_q  <= rdat_d;
            stat_q  <= stat_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: command frames in, bus cycles and response bytes out.
// Inputs change and outputs are sampled on the falling clock edge.
// The bench plays the Wishbone slave and the UART TX sink itself.
module tb_wb_byte_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel;
    logic        wb_ack, wb_err, wb_stall;

    int vectors     = 0;
    int miscompares = 0;

    wb_byte_master #(.TIMEOUT(1024), .CNT_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
    );

    always #5 clk = ~clk;

    // Offer one byte starting at a falling edge; returns on the falling edge after the handshake.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin @(negedge clk); n++; end
        if (!rx_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_byte rx_ready stuck: got 0 need 1 (byte %h)", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Take one response byte (tx_ready assumed high); returns on the following falling edge.
    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        while (!tx_valid && n < 50) begin @(negedge clk); n++; end
        if (!tx_valid) begin
            vectors++; miscompares++;
            $display("FAIL recv_byte tx_valid stuck: got 0 need 1");
        end
        b = tx_data;
        @(negedge clk);
    endtask

    task automatic send_read(input logic [7:0] a0);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(a0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, tx_data, tx_valid, rx_ready} !== 80'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got cyc%b stb%b we%b sel%h adr%h dat%h tx%h txv%b rxr%b need all 0",
                     wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_o, tx_data, tx_valid, rx_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rx_ready, tx_valid, wb_cyc} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_idle got rxr%b txv%b cyc%b need 1 0 0", rx_ready, tx_valid, wb_cyc);
        end
    endtask

    task automatic test_write;
        logic [7:0] b;
        send_byte(8'h57); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel, rx_ready} !== 8'b1111_1110) begin
            miscompares++;
            $display("FAIL wr_req got cyc%b stb%b we%b sel%h rxr%b need 1 1 1 f 0", wb_cyc, wb_stb, wb_we, wb_sel, rx_ready);
        end
        vectors++;
        if (wb_adr !== 32'h1000_0000 || wb_dat_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL wr_fields got adr %h dat %h need 10000000 deadbeef", wb_adr, wb_dat_o);
        end
        @(negedge clk);
        vectors++;
        if ({wb_cyc, wb_stb} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_wait got cyc%b stb%b need 1 0", wb_cyc, wb_stb);
        end
        wb_ack = 1'b1;
        @(negedge clk);
        wb_ack = 1'b0;
        vectors++;
        if ({tx_valid, wb_cyc} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_ack_latency got txv%b cyc%b need 1 0", tx_valid, wb_cyc);
        end
        recv_byte(b);
        vectors++;
        if (b !== 8'h4B) begin miscompares++; $display("FAIL wr_status got %h need 4b", b); end
        vectors++;
        if ({tx_valid, rx_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL wr_done got txv%b rxr%b need 0 1", tx_valid, rx_ready);
        end
    endtask

    task automatic test_read;
        logic [7:0] b;
        logic [7:0] e [5];
        e = '{8'h4B, 8'h12, 8'h34, 8'h56, 8'h78};
        send_read(8'h04);
        vectors++;
        if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'b110_1111 || wb_adr !== 32'h0000_0004) begin
            miscompares++;
            $display("FAIL rd_req got cyc%b stb%b we%b sel%h adr%h need 1 1 0 f 00000004", wb_cyc, wb_stb, wb_we, wb_sel, wb_adr);
        end
        // Ack in the same cycle the request is accepted.
        wb_ack = 1'b1; wb_dat_i = 32'h1234_5678;
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b);
            vectors++;
            if (b !== e[i]) begin miscompares++; $display("FAIL rd_byte%0d got %h need %h", i, b, e[i]); end
        end
        vectors++;
        if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL rd_end got txv%b need 0", tx_valid); end
    endtask

    task automatic test_stall;
        logic [7:0] b;
        logic [7:0] e [5];
        int hold = 0;
        e = '{8'h4B, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        wb_stall = 1'b1;
        send_read(8'h08);
        for (int k = 0; k < 6; k++) begin
            if (wb_stb && wb_adr == 32'h0000_0008) hold++;
            if (k == 5) wb_stall = 1'b0;
            @(negedge clk);
        end
        vectors++;
        if (hold != 6) begin miscompares++; $display("FAIL stall_hold got %0d cycles need 6", hold); end
        vectors++;
        if ({wb_cyc, wb_stb} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_accept got cyc%b stb%b need 1 0", wb_cyc, wb_stb);
        end
        wb_ack = 1'b1; wb_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b);
            vectors++;
            if (b !== e[i]) begin miscompares++; $display("FAIL stall_byte%0d got %h need %h", i, b, e[i]); end
        end
    endtask

    task automatic test_err_timeout;
        logic [7:0] b;
        int n = 0;
        send_read(8'h10);
        @(negedge clk);
        wb_err = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        wb_err = 1'b0; wb_dat_i = 32'h0;
        recv_byte(b);
        vectors++;
        if (b !== 8'h45) begin miscompares++; $display("FAIL err_status got %h need 45", b); end
        vectors++;
        if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL err_single got txv%b need 0", tx_valid); end

        send_read(8'h14);
        while (wb_cyc && n < 2000) begin n++; @(negedge clk); end
        vectors++;
        if (n != 1024) begin miscompares++; $display("FAIL tmo_cycles got %0d need 1024", n); end
        recv_byte(b);
        vectors++;
        if (b !== 8'h54) begin miscompares++; $display("FAIL tmo_status got %h need 54", b); end
        vectors++;
        if (tx_valid !== 1'b0) begin miscompares++; $display("FAIL tmo_single got txv%b need 0", tx_valid); end
    endtask

    task automatic test_resync_backpressure;
        logic [7:0] b;
        logic [7:0] e [5];
        int stable = 0;
        e = '{8'h4B, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        send_byte(8'h00); send_byte(8'hFF);
        send_read(8'h0C);
        vectors++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b110 || wb_adr !== 32'h0000_000C) begin
            miscompares++;
            $display("FAIL resync_req got cyc%b stb%b we%b adr%h need 1 1 0 0000000c", wb_cyc, wb_stb, wb_we, wb_adr);
        end
        wb_ack = 1'b1; wb_dat_i = 32'hA1B2_C3D4;
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_i = 32'h0;
        tx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_valid && tx_data == 8'h4B) stable++;
            @(negedge clk);
        end
        vectors++;
        if (stable != 10) begin miscompares++; $display("FAIL bp_hold got %0d stable cycles need 10", stable); end
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b);
            vectors++;
            if (b !== e[i]) begin miscompares++; $display("FAIL bp_byte%0d got %h need %h", i, b, e[i]); end
        end
    endtask

    task automatic test_reset_mid_wait;
        logic [7:0] b;
        logic [7:0] e [5];
        e = '{8'h4B, 8'h55, 8'hAA, 8'h55, 8'hAA};
        send_byte(8'h57); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        vectors++;
        if ({wb_cyc, wb_stb} !== 2'b10) begin
            miscompares++;
            $display("FAIL rstw_wait got cyc%b stb%b need 1 0", wb_cyc, wb_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({wb_cyc, wb_stb, tx_valid, rx_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rstw_async got cyc%b stb%b txv%b rxr%b need 0 0 0 0", wb_cyc, wb_stb, tx_valid, rx_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_read(8'h18);
        vectors++;
        if ({wb_cyc, wb_stb, wb_we} !== 3'b110 || wb_adr !== 32'h0000_0018) begin
            miscompares++;
            $display("FAIL rstw_req got cyc%b stb%b we%b adr%h need 1 1 0 00000018", wb_cyc, wb_stb, wb_we, wb_adr);
        end
        wb_ack = 1'b1; wb_dat_i = 32'h55AA_55AA;
        @(negedge clk);
        wb_ack = 1'b0; wb_dat_i = 32'h0;
        for (int i = 0; i < 5; i++) begin
            recv_byte(b);
            vectors++;
            if (b !== e[i]) begin miscompares++; $display("FAIL rstw_byte%0d got %h need %h", i, b, e[i]); end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wb_dat_i = 32'h0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_stall = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_stall();
        test_err_timeout();
        test_resync_backpressure();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
